// File: rtl/mole_controller.sv
// Mole generator and hit scorer closing the loop with the game-state FSM.
// Optional MOLE_PENALTY_EN: wrong-button presses cost points and retire the mole.
module mole_controller #(
    parameter int unsigned NUM_HOLES  = 4,
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned MOLE_UP_MS = 1000,
    parameter int unsigned GAP_MS     = 300,
    parameter int unsigned HIT_POINTS = 10,
    parameter int unsigned SCORE_MAX  = 1000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         play_flag,
    input  logic                         new_mole,
    input  logic [NUM_HOLES-1:0]         buttons,
    output logic [NUM_HOLES-1:0]         mole_onehot,
    output logic [$clog2(NUM_HOLES)-1:0] mole_idx,
    output logic                         mole_complete,
    output logic                         hit,
    output logic                         miss,
    output logic [11:0]                  score
);

    localparam int unsigned IDX_W     = $clog2(NUM_HOLES);
    localparam int unsigned SCORE_W   = 12;
    localparam int unsigned SUM_W     = SCORE_W + 1;
    localparam int unsigned CPM       = CLK_HZ / 1000;
    localparam int unsigned PRE_W     = $clog2(CPM);
    localparam int unsigned MS_MAX    = (MOLE_UP_MS > GAP_MS) ? MOLE_UP_MS : GAP_MS;
    localparam int unsigned MS_W      = $clog2(MS_MAX + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_REQ,
        ST_UP
    } state_e;

    state_e                 state_q, state_d;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [MS_W-1:0]        ms_q, ms_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [NUM_HOLES-1:0]   buttons_d_q;
    logic [NUM_HOLES-1:0]   mole_onehot_q, mole_onehot_d;
    logic [IDX_W-1:0]       mole_idx_q, mole_idx_d;
    logic                   mole_complete_q, mole_complete_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic [SCORE_W-1:0]     score_q, score_d;

    logic [NUM_HOLES-1:0]   rise_c;
    logic                   tick_c;
    logic                   gap_done_c;
    logic                   up_done_c;
    logic [IDX_W-1:0]       cand_c;
    logic [IDX_W-1:0]       pick_c;
    logic [SUM_W-1:0]       score_sum_c;
    logic [SCORE_W-1:0]     score_inc_c;
`ifdef MOLE_PENALTY_EN
    logic [SCORE_W-1:0]     score_dec_c;
`endif

    // Edge detect, ms prescaler terminal counts and score arithmetic
    always_comb begin
        rise_c      = buttons & ~buttons_d_q;
        tick_c      = (pre_q == PRE_W'(CPM - 1));
        gap_done_c  = tick_c && (ms_q == MS_W'(GAP_MS - 1));
        up_done_c   = tick_c && (ms_q == MS_W'(MOLE_UP_MS - 1));
        score_sum_c = SUM_W'(score_q) + SUM_W'(HIT_POINTS);
        score_inc_c = (score_sum_c > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                        : score_sum_c[SCORE_W-1:0];
`ifdef MOLE_PENALTY_EN
        score_dec_c = (score_q > SCORE_W'(HIT_POINTS)) ? (score_q - SCORE_W'(HIT_POINTS))
                                                       : '0;
`endif
    end

    // Hole choice: LFSR modulo hole count, bumped by one to avoid a back-to-back repeat
    always_comb begin
        cand_c = IDX_W'(lfsr_q % 16'(NUM_HOLES));
        pick_c = cand_c;
        if (cand_c == mole_idx_q) begin
            pick_c = (cand_c == IDX_W'(NUM_HOLES - 1)) ? '0 : (cand_c + IDX_W'(1));
        end
    end

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Next state and registered outputs
    always_comb begin
        state_d         = state_q;
        mole_onehot_d   = mole_onehot_q;
        mole_idx_d      = mole_idx_q;
        mole_complete_d = 1'b0;
        hit_d           = 1'b0;
        miss_d          = 1'b0;
        score_d         = score_q;

        if (!play_flag) begin
            state_d       = ST_IDLE;
            mole_onehot_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_done_c) begin
                        state_d         = ST_REQ;
                        mole_complete_d = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (new_mole) begin
                        state_d       = ST_UP;
                        mole_idx_d    = pick_c;
                        mole_onehot_d = NUM_HOLES'(1) << pick_c;
                    end
                end
                ST_UP: begin
                    // A hit outranks a coincident timeout or wrong-button press
                    if (rise_c[mole_idx_q]) begin
                        state_d       = ST_GAP;
                        mole_onehot_d = '0;
                        hit_d         = 1'b1;
                        score_d       = score_inc_c;
`ifdef MOLE_PENALTY_EN
                    end else if (|rise_c) begin
                        state_d       = ST_GAP;
                        mole_onehot_d = '0;
                        miss_d        = 1'b1;
                        score_d       = score_dec_c;
`endif
                    end else if (up_done_c) begin
                        state_d       = ST_GAP;
                        mole_onehot_d = '0;
                        miss_d        = 1'b1;
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    mole_onehot_d = '0;
                end
            endcase
        end
    end

    // Prescaler and ms counter restart on every state entry; only GAP and UP are timed
    always_comb begin
        pre_d = '0;
        ms_d  = '0;
        if ((state_d == state_q) && ((state_q == ST_GAP) || (state_q == ST_UP))) begin
            if (tick_c) begin
                ms_d = ms_q + MS_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
                ms_d  = ms_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            pre_q           <= '0;
            ms_q            <= '0;
            lfsr_q          <= LFSR_SEED;
            buttons_d_q     <= '0;
            mole_onehot_q   <= '0;
            mole_idx_q      <= '0;
            mole_complete_q <= 1'b0;
            hit_q           <= 1'b0;
            miss_q          <= 1'b0;
            score_q         <= '0;
        end else begin
            state_q         <= state_d;
            pre_q           <= pre_d;
            ms_q            <= ms_d;
            lfsr_q          <= lfsr_d;
            buttons_d_q     <= buttons;
            mole_onehot_q   <= mole_onehot_d;
            mole_idx_q      <= mole_idx_d;
            mole_complete_q <= mole_complete_d;
            hit_q           <= hit_d;
            miss_q          <= miss_d;
            score_q         <= score_d;
        end
    end

    assign mole_onehot   = mole_onehot_q;
    assign mole_idx      = mole_idx_q;
    assign mole_complete = mole_complete_q;
    assign hit           = hit_q;
    assign miss          = miss_q;
    assign score         = score_q;

endmodule
